timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  Memory-mapped timer/counter; responder on the CPU data-memory port (address, write data, write enable, read data).
//  CPU programs it with sw and samples it with lw.
//  Counts down from a preset value and raises irq at terminal count.
//  Sits beside the data memory, selected by the system address decode.
// PARAMETERS
//  CNT_W     32  counter/preset width (<=32; read data zero-extended)
//  PRESCALE  4   clocks per decrement; only used when TC_PRESCALE_EN defined (>=1)
// PORTS
//  clk    in   1       rising-edge clock; the only clock
//  rst    in   1       reset; asynchronous, active-low
//  addr   in   2       word select (byte addr [3:2]): 0=CTRL 1=PRESET 2=COUNT 3=reserved
//  we     in   1       write strobe; wd captured at clk edge when high and block selected
//  wd     in   32      write data
//  rd     out  32      read data; combinational from addr, same cycle (matches DM timing)
//  irq    out  1       interrupt request, active-high
// BEHAVIOUR
//  Regs: CTRL[0]=EN, CTRL[2:1]=MODE (00 one-shot, 01 auto-reload, 1x = one-shot), CTRL[3]=IM; others read 0.
//  PRESET: R/W. COUNT: read-only, writes ignored. addr 3: reads 0, writes ignored.
//  Reset (rst low, async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0; rd follows addr with zero regs; irq=0.
//  Register writes take effect at the edge where we=1; visible on rd the following cycle.
//  FSM (state in 2 bits):
//   IDLE: COUNT holds; EN=1 -> LOAD.
//   LOAD: COUNT<=PRESET; -> CNT.
//   CNT : EN=0 -> IDLE (COUNT frozen); COUNT==0 -> INT; else COUNT<=COUNT-1 per tick.
//   INT : mode one-shot: EN<=0, pend<=1, -> IDLE. mode auto-reload: -> LOAD, no pend.
//  tick = every clk (macro off). PRESET=N gives INT N+2 cycles after the EN write edge.
//  irq = IM & (pend | (state==INT & MODE==01)). One-shot is level until cleared; auto-reload is a 1-cycle pulse per period.
//  Any CTRL write clears pend; exception: INT in the same cycle sets it (set wins; no interrupt lost).
//  CTRL write in the INT cycle, one-shot: written EN value wins over hardware EN clear.
//  PRESET write during CNT: no effect on COUNT until next LOAD.
//  PRESET=0: LOAD->CNT->INT immediately (no wrap to all-ones).
//  COUNT decrement never underflows; it is checked against 0 before decrementing.
//  Async reset mid-count: immediate return to reset values; no irq glitch after release.
// CONFIGURATION
//  TC_PRESCALE_EN defined: CNT decrements only on a tick every PRESCALE clocks.
//   Prescale counter restarts at LOAD and holds outside CNT. LOAD/INT transitions are unaffected.
//  Not defined: tick every clock; PRESCALE ignored; no prescale logic synthesised.
// STRUCTURE
//  Shared package tc_pkg:
//   state localparams: IDLE=0, LOAD=1, CNT=2, INT=3
//   register word offsets: CTRL=0, PRESET=1, COUNT=2
//   CTRL bit indices: EN=0, MODE=2:1, IM=3; mode codes
//  Sub-module tc_prescaler (tick generator): instantiated only under TC_PRESCALE_EN.
//  Top holds the register file, FSM and read mux.
// TESTING
//  1 Reset: rst low mid-count, COUNT=5 -> all regs 0, irq=0 same cycle; stays 0 after release.
//  2 One-shot: PRESET=3, CTRL=0x9 -> COUNT reads 3,2,1,0; irq high at cycle 5 after write and holds;
//    CTRL read shows EN=0; CTRL write 0x8 drops irq.
//  3 Auto-reload: PRESET=2, CTRL=0xB -> 1-cycle irq pulses every 5 cycles; 4 pulses in 20 cycles.
//  4 Mask/edge cases: IM=0 one-shot -> irq stays 0 while pend=1; then IM=1 -> irq rises.
//    PRESET=0 -> INT 2 cycles after enable.
//  5 Collision: CTRL write 0x9 in the INT cycle -> pend set, irq=1, EN remains 1, FSM restarts via LOAD.
//    COUNT write ignored; addr 3 reads 0.
//  6 TC_PRESCALE_EN, PRESCALE=4, PRESET=2 -> COUNT steps every 4 clocks; irq 2+4*2 cycles after enable.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped timer/counter: FSM states, register map, CTRL fields.
package tc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } tcState_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;
  localparam int unsigned CtrlW       = 4;

  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

endpackage

// File: rtl/tc_prescaler.sv
// Tick generator for the timer: one tick every PRESCALE clocks while running, restarted on load.
module tc_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] psQ;

  assign tick = run && (psQ == PsLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psQ <= '0;
    end else if (restart) begin
      psQ <= '0;
    end else if (run) begin
      psQ <= tick ? '0 : psQ + PsW'(1);
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with terminal-count interrupt, one-shot or auto-reload.
// Optional clock prescaler enabled by defining TC_PRESCALE_EN.
module timer_counter
  import tc_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  if (CNT_W == 0 || CNT_W > 32 || PRESCALE == 0) begin : gBadParam
    $error("timer_counter: CNT_W must be 1..32 and PRESCALE at least 1");
  end

  logic [CtrlW-1:0] ctrlQ;
  logic [CNT_W-1:0] presetQ;
  logic [CNT_W-1:0] countQ;
  logic             pendQ;
  tcState_e         stateQ;

  logic ctrlWr;
  logic presetWr;
  logic enNext;
  logic autoReload;
  logic tick;

  assign ctrlWr     = we && (addr == AddrCtrl);
  assign presetWr   = we && (addr == AddrPreset);
  assign autoReload = (ctrlQ[CtrlModeMsb:CtrlModeLsb] == ModeAutoReload);
  // IDLE reacts to the EN value being written so a start leaves IDLE on the write edge itself.
  assign enNext     = ctrlWr ? wd[CtrlEnBit] : ctrlQ[CtrlEnBit];

`ifdef TC_PRESCALE_EN
  logic psRestart;
  logic psRun;

  assign psRestart = (stateQ == StLoad);
  assign psRun     = (stateQ == StCnt);

  tc_prescaler #(
    .PRESCALE(PRESCALE)
  ) uPrescaler (
    .clk    (clk),
    .rst    (rst),
    .restart(psRestart),
    .run    (psRun),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlQ   <= '0;
      presetQ <= '0;
      countQ  <= '0;
      pendQ   <= 1'b0;
      stateQ  <= StIdle;
    end else begin
      if (ctrlWr) begin
        ctrlQ <= wd[CtrlW-1:0];
        pendQ <= 1'b0;
      end
      if (presetWr) begin
        presetQ <= wd[CNT_W-1:0];
      end
      unique case (stateQ)
        StIdle: begin
          if (enNext) stateQ <= StLoad;
        end
        StLoad: begin
          countQ <= presetQ;
          stateQ <= StCnt;
        end
        StCnt: begin
          if (!ctrlQ[CtrlEnBit]) begin
            stateQ <= StIdle;
          end else if (countQ == '0) begin
            stateQ <= StInt;
          end else if (tick) begin
            countQ <= countQ - CNT_W'(1);
          end
        end
        StInt: begin
          if (autoReload) begin
            stateQ <= StLoad;
          end else begin
            // Terminal-count set beats a same-cycle CTRL write clear; written EN beats hw clear.
            pendQ  <= 1'b1;
            stateQ <= StIdle;
            if (!ctrlWr) ctrlQ[CtrlEnBit] <= 1'b0;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      AddrCtrl:   rd = 32'(ctrlQ);
      AddrPreset: rd = 32'(presetQ);
      AddrCount:  rd = 32'(countQ);
      default:    rd = '0;
    endcase
  end

  assign irq = ctrlQ[CtrlImBit] & (pendQ | ((stateQ == StInt) & autoReload));

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;

  int passCnt = 0;
  int totalCnt = 0;

  timer_counter #(
    .CNT_W   (32),
    .PRESCALE(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .addr(addr),
    .we  (we),
    .wd  (wd),
    .rd  (rd),
    .irq (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = 32'd0;
  endtask

  task automatic rdReg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0;
    cyc(2);
    for (int a = 0; a < 4; a++) begin
      rdReg(2'(a), v);
      totalCnt++;
      if (v !== 32'd0) $display("FAIL reset_rd%0d: got %h expected 0", a, v);
      else passCnt++;
    end
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else passCnt++;
    @(negedge clk) rst = 1'b1;
    cyc(1);
    wrReg(2'd1, 32'd7);
    wrReg(2'd0, 32'h1);
    cyc(3);
    rdReg(2'd2, v);
    totalCnt++;
    if (v !== 32'd5) $display("FAIL reset_midcount: got %0d expected 5", v);
    else passCnt++;
    rst = 1'b0;
    #1;
    for (int a = 0; a < 3; a++) begin
      rdReg(2'(a), v);
      totalCnt++;
      if (v !== 32'd0) $display("FAIL reset_async_rd%0d: got %h expected 0", a, v);
      else passCnt++;
    end
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL reset_async_irq: got %b expected 0", irq);
    else passCnt++;
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      rdReg(2'd2, v);
      totalCnt++;
      if (irq !== 1'b0 || v !== 32'd0)
        $display("FAIL reset_release%0d: irq=%b count=%0d expected 0/0", k, irq, v);
      else passCnt++;
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] v;
    int expCount[7];
    logic expIrq[7];
    expCount = '{3, 2, 1, 0, 0, 0, 0};
    expIrq   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wrReg(2'd1, 32'd3);
    wrReg(2'd0, 32'h9);
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      rdReg(2'd2, v);
      totalCnt++;
      if (v !== 32'(expCount[k]) || irq !== expIrq[k])
        $display("FAIL one_shot_c%0d: count=%0d irq=%b expected %0d/%b",
                 k + 1, v, irq, expCount[k], expIrq[k]);
      else passCnt++;
    end
    rdReg(2'd0, v);
    totalCnt++;
    if (v !== 32'h8) $display("FAIL one_shot_ctrl: got %h expected 8", v);
    else passCnt++;
    wrReg(2'd0, 32'h8);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL one_shot_clear: irq=%b expected 0", irq);
    else passCnt++;
  endtask

  task automatic test_auto_reload();
    int pulses;
    logic expIrq;
    pulses = 0;
    wrReg(2'd1, 32'd2);
    wrReg(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      expIrq = (k % 5 == 4);
      totalCnt++;
      if (irq !== expIrq) $display("FAIL auto_reload_c%0d: irq=%b expected %b", k, irq, expIrq);
      else passCnt++;
      if (irq === 1'b1) pulses++;
    end
    totalCnt++;
    if (pulses !== 4) $display("FAIL auto_reload_pulses: got %0d expected 4", pulses);
    else passCnt++;
    wrReg(2'd0, 32'h0);
    cyc(2);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL auto_reload_stop: irq=%b expected 0", irq);
    else passCnt++;
  endtask

  task automatic test_mask();
    logic [31:0] v;
    logic expIrq[6];
    wrReg(2'd1, 32'd1);
    wrReg(2'd0, 32'h1);
    cyc(6);
    rdReg(2'd0, v);
    totalCnt++;
    if (v !== 32'h0 || irq !== 1'b0)
      $display("FAIL mask_hold: ctrl=%h irq=%b expected 0/0", v, irq);
    else passCnt++;
    wrReg(2'd0, 32'h0);
    wrReg(2'd0, 32'h1);
    cyc(3);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL mask_int_cycle: irq=%b expected 0", irq);
    else passCnt++;
    wrReg(2'd0, 32'h8);
    rdReg(2'd0, v);
    totalCnt++;
    if (irq !== 1'b1 || v !== 32'h8)
      $display("FAIL mask_unmask: irq=%b ctrl=%h expected 1/8", irq, v);
    else passCnt++;
    cyc(2);
    totalCnt++;
    if (irq !== 1'b1) $display("FAIL mask_level: irq=%b expected 1", irq);
    else passCnt++;
    expIrq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    wrReg(2'd1, 32'd0);
    wrReg(2'd0, 32'hB);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      rdReg(2'd2, v);
      totalCnt++;
      if (irq !== expIrq[k] || v !== 32'd0)
        $display("FAIL preset0_c%0d: irq=%b count=%h expected %b/0", k + 1, irq, v, expIrq[k]);
      else passCnt++;
    end
    wrReg(2'd0, 32'h0);
    cyc(2);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    wrReg(2'd1, 32'd1);
    wrReg(2'd0, 32'h9);
    cyc(3);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL collide_pre: irq=%b expected 0", irq);
    else passCnt++;
    wrReg(2'd0, 32'h9);
    rdReg(2'd0, v);
    totalCnt++;
    if (irq !== 1'b1 || v !== 32'h9)
      $display("FAIL collide_set: irq=%b ctrl=%h expected 1/9", irq, v);
    else passCnt++;
    cyc(2);
    rdReg(2'd2, v);
    totalCnt++;
    if (v !== 32'd1 || irq !== 1'b1)
      $display("FAIL collide_reload: count=%0d irq=%b expected 1/1", v, irq);
    else passCnt++;
    cyc(3);
    wrReg(2'd0, 32'h0);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL collide_clear: irq=%b expected 0", irq);
    else passCnt++;
    wrReg(2'd2, 32'h55);
    rdReg(2'd2, v);
    totalCnt++;
    if (v !== 32'd0) $display("FAIL count_ro: got %h expected 0", v);
    else passCnt++;
    rdReg(2'd1, v);
    totalCnt++;
    if (v !== 32'd1) $display("FAIL preset_keep: got %h expected 1", v);
    else passCnt++;
    wrReg(2'd3, 32'hFFFF_FFFF);
    rdReg(2'd3, v);
    totalCnt++;
    if (v !== 32'd0) $display("FAIL addr3: got %h expected 0", v);
    else passCnt++;
    rdReg(2'd0, v);
    totalCnt++;
    if (v !== 32'd0) $display("FAIL addr3_ctrl: got %h expected 0", v);
    else passCnt++;
    // PRESET rewrite mid-count must not disturb COUNT; EN=0 freezes COUNT.
    wrReg(2'd1, 32'd4);
    wrReg(2'd0, 32'h1);
    cyc(1);
    wrReg(2'd1, 32'd9);
    rdReg(2'd2, v);
    totalCnt++;
    if (v !== 32'd3) $display("FAIL preset_midcnt: count=%0d expected 3", v);
    else passCnt++;
    cyc(1);
    wrReg(2'd0, 32'h0);
    cyc(2);
    rdReg(2'd2, v);
    totalCnt++;
    if (v !== 32'd1) $display("FAIL disable_freeze: count=%0d expected 1", v);
    else passCnt++;
  endtask

`ifdef TC_PRESCALE_EN
  task automatic test_prescale();
    logic [31:0] v;
    int expCount[11];
    logic expIrq;
    expCount = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0};
    wrReg(2'd1, 32'd2);
    wrReg(2'd0, 32'h9);
    for (int k = 0; k < 11; k++) begin
      cyc(1);
      rdReg(2'd2, v);
      expIrq = (k == 10);
      totalCnt++;
      if (v !== 32'(expCount[k]) || irq !== expIrq)
        $display("FAIL prescale_c%0d: count=%0d irq=%b expected %0d/%b",
                 k + 1, v, irq, expCount[k], expIrq);
      else passCnt++;
    end
    wrReg(2'd0, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mask();
    test_collision();
`ifdef TC_PRESCALE_EN
    test_prescale();
`endif
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
